// File: rtl/vault_pkg.sv
// Shared encodings for the puzzle vault: FSM state codes and time-lock status codes.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package vault_pkg;

  // The stage output carries these codes directly, so the values are fixed.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SWITCH  = 3'd1,
    ST_DIR     = 3'd2,
    ST_PLATE   = 3'd3,
    ST_DONE    = 3'd4,
    ST_LOCKOUT = 3'd5,
    ST_ALARM   = 3'd6
  } vault_state_t;

  localparam logic [1:0] TL_NORMAL  = 2'b00;
  localparam logic [1:0] TL_LOCKOUT = 2'b01;
  localparam logic [1:0] TL_ALARM   = 2'b10;
  localparam logic [1:0] TL_DONE    = 2'b11;

  function automatic logic [1:0] tl_code(input vault_state_t s);
    case (s)
      ST_LOCKOUT: tl_code = TL_LOCKOUT;
      ST_ALARM:   tl_code = TL_ALARM;
      ST_DONE:    tl_code = TL_DONE;
      default:    tl_code = TL_NORMAL;
    endcase
  endfunction

  // States in which the player is expected to act and the inactivity timer runs.
  function automatic logic is_wait_state(input vault_state_t s);
    is_wait_state = (s == ST_SWITCH) || (s == ST_DIR) || (s == ST_PLATE);
  endfunction

endpackage

// File: rtl/plate_seq_matcher.sv
// Tracks progress through the pressure-plate sequence with hold-tolerant entry detection.
// Latency: entry/match/last flags are combinational on the current plate; progress updates next edge.
// Backpressure: none; every enabled cycle is evaluated, repeated equal values are ignored.
//
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   i_clr          : drop all progress (index, last value, first-entry flag)
//   i_en           : plate-stage enable qualified by the FSM being in PLATE
//   i_plate        : current plate value
//   o_entry        : this cycle is a new entry
//   o_match        : current plate equals the expected sequence element
//   o_last         : expected element is the final one of the sequence
module plate_seq_matcher
  import vault_pkg::*;
#(
  parameter int                           PLATE_W   = 8,
  parameter int                           SEQ_LEN   = 3,
  parameter logic [SEQ_LEN*PLATE_W-1:0]   PLATE_SEQ = {8'hF0, 8'hCC, 8'hAA}
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clr,
  input  logic               i_en,
  input  logic [PLATE_W-1:0] i_plate,
  output logic               o_entry,
  output logic               o_match,
  output logic               o_last
);

  localparam int IDX_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;

  logic [IDX_W-1:0]   r_idx;
  logic [PLATE_W-1:0] r_last_val;
  logic               r_have;
  logic [PLATE_W-1:0] w_exp;

  // Element 0 sits in the LSBs of PLATE_SEQ.
  always_comb begin
    w_exp = '0;
    for (int k = 0; k < SEQ_LEN; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_exp = PLATE_SEQ[k*PLATE_W +: PLATE_W];
      end
    end
  end

  // A held plate produces one entry: only the first enabled cycle or a changed value counts.
  assign o_entry = i_en && (!r_have || (i_plate != r_last_val));
  assign o_match = (i_plate == w_exp);
  assign o_last  = (r_idx == IDX_W'(SEQ_LEN - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx      <= '0;
      r_last_val <= '0;
      r_have     <= 1'b0;
    end else if (i_clr) begin
      r_idx      <= '0;
      r_last_val <= '0;
      r_have     <= 1'b0;
    end else if (o_entry) begin
      r_last_val <= i_plate;
      r_have     <= 1'b1;
      if (o_match && !o_last) begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/puzzle_vault_ctrl.sv
// Puzzle vault FSM: switch, direction and plate stages with inactivity timeout, lockout and alarm.
// Latency: every output is registered; a qualifying input is reflected one clock later.
// Backpressure: none; strobes for stages other than the current one are simply ignored.
//
// Ports:
//   clk, reset     : clock, async active-low reset
//   code_in        : start strobe (IDLE only)
//   check2/switch_in, valid3/dir_in, check4/plate_in : stage strobes and their data
//   stage          : current state code
//   all_done/vault : level, puzzle solved
//   escape         : one-cycle pulse on first DONE cycle
//   alarm          : sticky alarm level
//   time_lock_out  : 00 normal, 01 lockout, 10 alarm, 11 done
//   fail_cnt       : failures since reset or solve
module puzzle_vault_ctrl
  import vault_pkg::*;
#(
  parameter int                         SW_W           = 4,
  parameter int                         PLATE_W        = 8,
  parameter int                         SEQ_LEN        = 3,
  parameter int                         MAX_FAILS      = 3,
  parameter int                         LOCK_CYCLES    = 16,
  parameter int                         TIMEOUT_CYCLES = 64,
  parameter logic [SW_W-1:0]            SW_KEY         = 4'b1010,
  parameter logic [2:0]                 DIR_KEY        = 3'b010,
  parameter logic [SEQ_LEN*PLATE_W-1:0] PLATE_SEQ      = {8'hF0, 8'hCC, 8'hAA}
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           code_in,
  input  logic                           check2,
  input  logic [SW_W-1:0]                switch_in,
  input  logic                           valid3,
  input  logic [2:0]                     dir_in,
  input  logic                           check4,
  input  logic [PLATE_W-1:0]             plate_in,
  output logic [2:0]                     stage,
  output logic                           all_done,
  output logic                           vault,
  output logic                           escape,
  output logic                           alarm,
  output logic [1:0]                     time_lock_out,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt
);

  localparam int FC_W = $clog2(MAX_FAILS + 1);
  localparam int IT_W = $clog2(TIMEOUT_CYCLES);
  localparam int LT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  vault_state_t    r_state;
  vault_state_t    w_next;
  logic [IT_W-1:0] r_idle_tmr;
  logic [LT_W-1:0] r_lock_tmr;
  logic [FC_W-1:0] r_fail_cnt;
  logic [FC_W-1:0] w_fail_inc;
  logic            r_done;
  logic            r_escape;
  logic            r_alarm;
  logic [1:0]      r_tlo;
  logic            w_fail;
  logic            w_timeout;
  logic            w_entry;
  logic            w_match;
  logic            w_last;
  logic            w_plate_en;
  logic            w_plate_clr;

  assign w_timeout   = (r_idle_tmr == IT_W'(TIMEOUT_CYCLES - 1));
  assign w_fail_inc  = r_fail_cnt + FC_W'(1);
  assign w_plate_en  = check4 && (r_state == ST_PLATE);
  // Progress is dropped as soon as a failure happens and whenever we are outside PLATE.
  assign w_plate_clr = (r_state != ST_PLATE) || w_fail;

  plate_seq_matcher #(
    .PLATE_W   (PLATE_W),
    .SEQ_LEN   (SEQ_LEN),
    .PLATE_SEQ (PLATE_SEQ)
  ) u_matcher (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_clr   (w_plate_clr),
    .i_en    (w_plate_en),
    .i_plate (plate_in),
    .o_entry (w_entry),
    .o_match (w_match),
    .o_last  (w_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A strobe in its own stage always wins over a timeout in the same cycle.
  always_comb begin
    w_next = r_state;
    w_fail = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (code_in) w_next = ST_SWITCH;
      end
      ST_SWITCH: begin
        if (check2) begin
          if (switch_in == SW_KEY) w_next = ST_DIR;
          else                     w_fail = 1'b1;
        end else if (w_timeout) begin
          w_fail = 1'b1;
        end
      end
      ST_DIR: begin
        if (valid3) begin
          if (dir_in == DIR_KEY) w_next = ST_PLATE;
          else                   w_fail = 1'b1;
        end else if (w_timeout) begin
          w_fail = 1'b1;
        end
      end
      ST_PLATE: begin
        if (w_entry) begin
          if (!w_match)    w_fail = 1'b1;
          else if (w_last) w_next = ST_DONE;
        end else if (w_timeout) begin
          w_fail = 1'b1;
        end
      end
      ST_LOCKOUT: begin
        if (r_lock_tmr == LT_W'(LOCK_CYCLES - 1)) w_next = ST_IDLE;
      end
      default: begin
        // DONE and ALARM hold until reset.
        w_next = r_state;
      end
    endcase
    if (w_fail) begin
      w_next = (w_fail_inc == FC_W'(MAX_FAILS)) ? ST_ALARM : ST_LOCKOUT;
    end
  end

  // Timers and failure bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idle_tmr <= '0;
      r_lock_tmr <= '0;
      r_fail_cnt <= '0;
    end else begin
      if ((w_next != r_state) || w_entry) begin
        r_idle_tmr <= '0;
      end else if (is_wait_state(r_state)) begin
        r_idle_tmr <= r_idle_tmr + IT_W'(1);
      end else begin
        r_idle_tmr <= '0;
      end

      if ((r_state == ST_LOCKOUT) && (w_next == ST_LOCKOUT)) begin
        r_lock_tmr <= r_lock_tmr + LT_W'(1);
      end else begin
        r_lock_tmr <= '0;
      end

      if (w_fail) begin
        r_fail_cnt <= w_fail_inc;
      end else if ((w_next == ST_DONE) && (r_state != ST_DONE)) begin
        r_fail_cnt <= '0;
      end
    end
  end

  // Status outputs are registered from the next state so they line up with stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_done   <= 1'b0;
      r_escape <= 1'b0;
      r_alarm  <= 1'b0;
      r_tlo    <= TL_NORMAL;
    end else begin
      r_done   <= (w_next == ST_DONE);
      r_escape <= (w_next == ST_DONE) && (r_state != ST_DONE);
      r_alarm  <= (w_next == ST_ALARM);
      r_tlo    <= tl_code(w_next);
    end
  end

  assign stage         = r_state;
  assign all_done      = r_done;
  assign vault         = r_done;
  assign escape        = r_escape;
  assign alarm         = r_alarm;
  assign time_lock_out = r_tlo;
  assign fail_cnt      = r_fail_cnt;

endmodule

// File: tb/tb_puzzle_vault_ctrl.sv
// Bench for puzzle_vault_ctrl: cycle model comparison plus directed literal checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_puzzle_vault_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       code_in, check2, valid3, check4;
  logic [3:0] switch_in;
  logic [2:0] dir_in;
  logic [7:0] plate_in;
  logic [3:0] plate4;

  logic [2:0] stage;
  logic       all_done, vault, escape, alarm;
  logic [1:0] tlo;
  logic [1:0] fail_cnt;

  logic [2:0] d1_stage;
  logic       d1_all_done, d1_vault, d1_escape, d1_alarm;
  logic [1:0] d1_tlo;
  logic [0:0] d1_fail;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  puzzle_vault_ctrl dut (
    .clk(clk), .reset(reset), .code_in(code_in), .check2(check2), .switch_in(switch_in),
    .valid3(valid3), .dir_in(dir_in), .check4(check4), .plate_in(plate_in),
    .stage(stage), .all_done(all_done), .vault(vault), .escape(escape), .alarm(alarm),
    .time_lock_out(tlo), .fail_cnt(fail_cnt)
  );

  puzzle_vault_ctrl #(
    .SW_W(4), .PLATE_W(4), .SEQ_LEN(1), .MAX_FAILS(1), .PLATE_SEQ(4'h5)
  ) dut1 (
    .clk(clk), .reset(reset), .code_in(code_in), .check2(check2), .switch_in(switch_in),
    .valid3(valid3), .dir_in(dir_in), .check4(check4), .plate_in(plate4),
    .stage(d1_stage), .all_done(d1_all_done), .vault(d1_vault), .escape(d1_escape),
    .alarm(d1_alarm), .time_lock_out(d1_tlo), .fail_cnt(d1_fail)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (main instance, default parameters) ----------------
  int         m_stage = 0, m_fails = 0, m_wait = 0, m_lock_left = 0, m_pos = 0, m_nxt = 0;
  bit         m_have = 0, m_esc = 0, m_fail = 0, m_ent = 0;
  logic [7:0] m_prev = 8'h00;
  logic [7:0] seq [3] = '{8'hAA, 8'hCC, 8'hF0};

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_stage = 0; m_fails = 0; m_wait = 0; m_lock_left = 0;
      m_pos = 0; m_have = 0; m_prev = 8'h00; m_esc = 0;
    end else begin
      m_fail = 0; m_ent = 0; m_nxt = m_stage; m_esc = 0;
      case (m_stage)
        0: if (code_in) m_nxt = 1;
        1: begin
          if (check2) begin
            if (switch_in == 4'b1010) m_nxt = 2; else m_fail = 1;
          end else if (m_wait == 63) m_fail = 1;
        end
        2: begin
          if (valid3) begin
            if (dir_in == 3'b010) m_nxt = 3; else m_fail = 1;
          end else if (m_wait == 63) m_fail = 1;
        end
        3: begin
          m_ent = check4 && (!m_have || plate_in != m_prev);
          if (m_ent) begin
            m_have = 1; m_prev = plate_in;
            if (plate_in != seq[m_pos]) m_fail = 1;
            else if (m_pos == 2) m_nxt = 4;
            else m_pos++;
          end else if (m_wait == 63) m_fail = 1;
        end
        5: begin
          m_lock_left--;
          if (m_lock_left == 0) m_nxt = 0;
        end
        default: ;
      endcase
      if (m_fail) begin
        m_fails++;
        m_nxt = (m_fails == 3) ? 6 : 5;
        m_lock_left = 16; m_pos = 0; m_have = 0;
      end
      if (m_nxt == 4 && m_stage != 4) begin
        m_fails = 0; m_esc = 1;
      end
      if (m_nxt != m_stage || m_ent) m_wait = 0; else m_wait++;
      m_stage = m_nxt;
    end
  end

  function automatic logic [1:0] exp_tlo(input int s);
    case (s)
      5:       exp_tlo = 2'b01;
      6:       exp_tlo = 2'b10;
      4:       exp_tlo = 2'b11;
      default: exp_tlo = 2'b00;
    endcase
  endfunction

  always @(negedge clk) begin
    chk("m_stage", stage, m_stage);
    chk("m_all_done", all_done, m_stage == 4);
    chk("m_vault", vault, m_stage == 4);
    chk("m_escape", escape, m_esc);
    chk("m_alarm", alarm, m_stage == 6);
    chk("m_tlo", tlo, exp_tlo(m_stage));
    chk("m_fail_cnt", fail_cnt, m_fails);
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    code_in = 0; check2 = 0; valid3 = 0; check4 = 0;
    switch_in = 4'h0; dir_in = 3'h0; plate_in = 8'h00; plate4 = 4'h0;
  endtask

  task automatic idle(input int cycles);
    clr_in();
    repeat (cycles) cyc();
  endtask

  task automatic do_reset();
    clr_in();
    reset = 0;
    cyc();
    chk("rst_stage", stage, 0);
    reset = 1;
    cyc();
  endtask

  task automatic enter_dir();
    clr_in();
    code_in = 1;
    cyc();
    chk("to_switch", stage, 1);
    code_in = 0; check2 = 1; switch_in = 4'b1010;
    cyc();
    chk("to_dir", stage, 2);
    clr_in();
  endtask

  task automatic enter_plate();
    enter_dir();
    valid3 = 1; dir_in = 3'b010;
    cyc();
    chk("to_plate", stage, 3);
    clr_in();
  endtask

  task automatic plate(input logic [7:0] v, input logic [3:0] v4);
    check4 = 1; plate_in = v; plate4 = v4;
    cyc();
  endtask

  // Counts lockout length including the already-observed first lockout cycle.
  task automatic wait_lock();
    int cnt;
    clr_in();
    cnt = 0;
    while (stage == 3'd5 && cnt < 40) begin
      cyc();
      cnt++;
    end
    chk("lock_len", cnt, 16);
    chk("lock_exit_idle", stage, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_in();
    reset = 0;
    repeat (2) cyc();
    chk("rst_stage0", stage, 0);
    chk("rst_all_done", all_done, 0);
    chk("rst_vault", vault, 0);
    chk("rst_escape", escape, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_tlo", tlo, 0);
    chk("rst_fail", fail_cnt, 0);
    reset = 1;
    cyc();

    // Strobes of later stages are ignored while IDLE.
    check2 = 1; switch_in = 4'b1010; valid3 = 1; dir_in = 3'b010;
    cyc();
    chk("idle_ignore", stage, 0);

    // Happy path with held plates.
    enter_plate();
    plate(8'hAA, 4'h0); chk("hp_aa", stage, 3);
    plate(8'hAA, 4'h0);
    plate(8'hCC, 4'h0);
    plate(8'hCC, 4'h0); chk("hp_cc", stage, 3);
    plate(8'hF0, 4'h0);
    chk("hp_done", stage, 4);
    chk("hp_escape1", escape, 1);
    chk("hp_vault", vault, 1);
    chk("hp_all_done", all_done, 1);
    chk("hp_tlo", tlo, 2'b11);
    plate(8'hF0, 4'h0);
    chk("hp_escape0", escape, 0);
    idle(3);
    chk("hp_terminal", stage, 4);

    // Wrong switch, lockout, retry.
    do_reset();
    code_in = 1; cyc();
    code_in = 0; check2 = 1; switch_in = 4'b0101; cyc();
    chk("sw_lock", stage, 5);
    chk("sw_fail1", fail_cnt, 1);
    chk("sw_tlo", tlo, 2'b01);
    wait_lock();
    enter_plate();
    plate(8'hAA, 4'h0); plate(8'hCC, 4'h0); plate(8'hF0, 4'h0);
    chk("retry_done", stage, 4);
    chk("retry_fail0", fail_cnt, 0);

    // Three wrong directions -> alarm.
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      enter_dir();
      valid3 = 1; dir_in = 3'b011;
      cyc();
      clr_in();
      chk("dir_fail_cnt", fail_cnt, k);
      if (k < 3) wait_lock();
    end
    chk("alarm_stage", stage, 6);
    chk("alarm_level", alarm, 1);
    chk("alarm_tlo", tlo, 2'b10);
    code_in = 1; check2 = 1; switch_in = 4'b1010; valid3 = 1; dir_in = 3'b010;
    repeat (4) cyc();
    chk("alarm_sticky", stage, 6);

    // DIR timeout, then strobe on the last allowed cycle.
    do_reset();
    enter_dir();
    idle(63);
    chk("to_still_dir", stage, 2);
    idle(1);
    chk("to_fail", stage, 5);
    chk("to_fail_cnt", fail_cnt, 1);
    wait_lock();
    enter_dir();
    idle(63);
    valid3 = 1; dir_in = 3'b010;
    cyc();
    clr_in();
    chk("to_edge_plate", stage, 3);
    chk("to_edge_nofail", fail_cnt, 1);

    // Wrong third plate, then reset mid-PLATE.
    plate(8'hAA, 4'h0); plate(8'hCC, 4'h0); plate(8'h11, 4'h0);
    chk("pl_fail", stage, 5);
    chk("pl_fail_cnt", fail_cnt, 2);
    wait_lock();
    enter_plate();
    plate(8'hAA, 4'h0);
    clr_in();
    chk("mid_plate", stage, 3);
    #2;
    reset = 0;
    #1;
    chk("arst_stage", stage, 0);
    chk("arst_fail", fail_cnt, 0);
    chk("arst_tlo", tlo, 0);
    chk("arst_flags", {all_done, vault, escape, alarm}, 4'b0000);
    cyc();
    reset = 1;
    cyc();

    // Single-element sequence, single allowed failure.
    enter_plate();
    chk("d1_plate", d1_stage, 3);
    plate(8'h00, 4'h5);
    chk("d1_done", d1_stage, 4);
    chk("d1_escape", d1_escape, 1);
    chk("d1_vault", d1_vault, 1);
    chk("d1_tlo_done", d1_tlo, 2'b11);
    do_reset();
    enter_plate();
    plate(8'h00, 4'h9);
    chk("d1_alarm_stage", d1_stage, 6);
    chk("d1_alarm", d1_alarm, 1);
    chk("d1_fail", d1_fail, 1);
    chk("d1_tlo_alarm", d1_tlo, 2'b10);
    clr_in();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
